ps2_key_ctrl: RTL
=================

# ps2_key_ctrl

Scancode sequencing controller between the PS/2 receiver FIFO (`ps2_keyboard`: `data`/`ready`/`nextdata_n`/`overflow`) and the display/ASCII path. It pops one byte per handshake and parses the set-2 prefixes E0 (extended) and F0 (break). It publishes the currently held key and a one-cycle press event. Typematic repeats are suppressed from the press count, and stale prefixes are flushed by timeout.

## Interface
Parameters:
- `TIMEOUT_CYC`, default 1_000_000: clk cycles a pending prefix may wait for its code byte.
- `TW`, default 20: width of the timeout counter; must satisfy 2^TW > TIMEOUT_CYC.

Ports:
- `clk`  in  1: system clock, single clock domain.
- `clrn`  in  1: reset, asynchronous, active-high (1 = reset).
- `ready`  in  1: FIFO non-empty; `fifo_data` valid.
- `fifo_data`  in  8: FIFO head byte.
- `overflow`  in  1: FIFO overflow flag.
- `nextdata_n`  out  1: active-low pop strobe, registered.
- `key_code`  out  8: scancode of the held or last key.
- `key_ext`  out  1: `key_code` was E0-prefixed.
- `key_valid`  out  1: a key is currently held.
- `key_pressed`  out  1: one-cycle pulse on a new make.
- `key_repeat`  out  1: one-cycle pulse on a typematic repeat.
- `key_count`  out  8: count of new makes, wraps 255->0.
- `err_overflow`  out  1: sticky; set when `overflow` is seen.

## Operation
- Reset values: `nextdata_n`=1, `key_code`=0, `key_ext`=0, `key_valid`=0, `key_pressed`=0, `key_repeat`=0, `key_count`=0, `err_overflow`=0. Internal state: FSM=IDLE, `brk_pend`=0, `ext_pend`=0, timeout counter=0.
- FSM states: IDLE, POP, SETTLE.
  - IDLE: when `ready`=1, latch `fifo_data` into `rx_byte` and go to POP.
  - POP: `nextdata_n`=0 for this cycle only. Decode `rx_byte`, then go to SETTLE.
  - SETTLE: `nextdata_n`=1. Go to IDLE unconditionally, which lets the FIFO update `ready`.
- Decode of `rx_byte` in POP:
  - E0: set `ext_pend`=1.
  - F0: set `brk_pend`=1.
  - Any other byte with `brk_pend`=1 (break):
    - If byte==`key_code` and `ext_pend`==`key_ext` and `key_valid`=1, clear `key_valid`. `key_code` and `key_ext` are kept.
    - Otherwise the break is ignored.
    - Clear both prefix flags.
  - Any other byte with `brk_pend`=0 (make):
    - If `key_valid`=1 and byte and `ext_pend` match the held key: pulse `key_repeat`; count is unchanged.
    - Otherwise: `key_code`<=byte, `key_ext`<=`ext_pend`, `key_valid`<=1, pulse `key_pressed`, `key_count`<=`key_count`+1 (mod 256).
    - Clear both prefix flags.
- Only one held key is tracked. A make of a different key replaces the held key and counts as a new press. A later break of the replaced key is ignored.
- Prefix timeout:
  - The counter is cleared whenever a byte is decoded, and counts while `brk_pend`|`ext_pend` is set.
  - When the count reaches `TIMEOUT_CYC`, clear both prefix flags and the counter.
  - If a decode and the timeout fall in the same cycle, the decode wins.
- `err_overflow`: set in any cycle with `overflow`=1, in every state. It is cleared only by reset. Decoding continues after overflow.

## Timing
- `ready` rising in IDLE produces `nextdata_n` low on the next cycle (POP). The decode result is visible one cycle after POP.
- `key_pressed` and `key_repeat` are high for exactly the cycle after POP. They are never high together.
- Throughput: at most one byte per 3 cycles.
- `ready` and `fifo_data` are ignored in POP and SETTLE. `nextdata_n` is never low for two consecutive cycles.
- With `ready` held high (FIFO backlog), the FSM cycles IDLE->POP->SETTLE->IDLE continuously with no idle gap.
- Reset asserted in any state forces all outputs to their reset values immediately, including `nextdata_n`=1 mid-POP. After release the FSM starts in IDLE and performs no partial pop.

## Test plan
- Feed 1C after reset -> `nextdata_n` low exactly 1 cycle; `key_code`=1C, `key_ext`=0, `key_valid`=1; `key_pressed` pulses once; `key_count`=1.
- Feed 1C,1C,1C,F0,1C -> `key_repeat` pulses 2 times; `key_count` stays 1; `key_valid`=0 after the final 1C; `key_code` stays 1C.
- Feed E0,75 then E0,F0,75 -> `key_code`=75, `key_ext`=1, `key_count`+1; then `key_valid`=0. Feed plain 75 after the E0 make -> counted as a new press.
- Feed 256 make/break pairs of 1C,F0,1C -> `key_count` wraps to 00 and shows 256 `key_pressed` pulses. Hold `overflow`=1 for one cycle -> `err_overflow`=1 until reset.
- Feed F0, idle for `TIMEOUT_CYC`+1 cycles (use `TIMEOUT_CYC`=16), then 2B -> treated as a make: `key_code`=2B, `key_valid`=1, `key_count`+1.
- Assert `clrn` during POP with `ready`=1 -> `nextdata_n`=1 in the same cycle and all outputs reset. After release with a 1C pending -> normal single pop and `key_count`=1.

Source files
------------

// File: rtl/ps2_key_ctrl_if.sv
// Signal bundle between the PS/2 receiver FIFO / key consumer and ps2_key_ctrl.
// The slave side is the controller; the master side is the FIFO plus key consumer.
interface ps2_key_ctrl_if;
    logic       ready;
    logic [7:0] fifo_data;
    logic       overflow;
    logic       nextdata_n;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_valid;
    logic       key_pressed;
    logic       key_repeat;
    logic [7:0] key_count;
    logic       err_overflow;

    modport master (
        output ready,
        output fifo_data,
        output overflow,
        input  nextdata_n,
        input  key_code,
        input  key_ext,
        input  key_valid,
        input  key_pressed,
        input  key_repeat,
        input  key_count,
        input  err_overflow
    );

    modport slave (
        input  ready,
        input  fifo_data,
        input  overflow,
        output nextdata_n,
        output key_code,
        output key_ext,
        output key_valid,
        output key_pressed,
        output key_repeat,
        output key_count,
        output err_overflow
    );
endinterface

// File: rtl/ps2_key_ctrl.sv
// Pops set-2 scancodes from the PS/2 FIFO, resolves E0/F0 prefixes and tracks one held key.
// Emits press/repeat pulses, a wrapping press counter and a sticky overflow flag.
module ps2_key_ctrl #(
    parameter int TIMEOUT_CYC = 1_000_000,
    parameter int TW          = 20
) (
    input logic           clk,
    input logic           clrn,
    ps2_key_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        POP    = 2'd1,
        SETTLE = 2'd2
    } state_t;

    localparam logic [7:0]    CODE_EXT   = 8'hE0;
    localparam logic [7:0]    CODE_BRK   = 8'hF0;
    localparam logic [TW-1:0] TMO_LIMIT  = TW'(TIMEOUT_CYC);

    state_t        state_q, state_d;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic          brk_pend_q, brk_pend_d;
    logic          ext_pend_q, ext_pend_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          nextdata_n_q, nextdata_n_d;
    logic [7:0]    key_code_q, key_code_d;
    logic          key_ext_q, key_ext_d;
    logic          key_valid_q, key_valid_d;
    logic          key_pressed_q, key_pressed_d;
    logic          key_repeat_q, key_repeat_d;
    logic [7:0]    key_count_q, key_count_d;
    logic          err_overflow_q, err_overflow_d;

    logic          same_key;

    // A byte names the held key only if the extended flag agrees as well.
    assign same_key = (rx_byte_q == key_code_q) && (ext_pend_q == key_ext_q);

    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            state_q        <= IDLE;
            rx_byte_q      <= 8'h00;
            brk_pend_q     <= 1'b0;
            ext_pend_q     <= 1'b0;
            tmo_q          <= '0;
            nextdata_n_q   <= 1'b1;
            key_code_q     <= 8'h00;
            key_ext_q      <= 1'b0;
            key_valid_q    <= 1'b0;
            key_pressed_q  <= 1'b0;
            key_repeat_q   <= 1'b0;
            key_count_q    <= 8'h00;
            err_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            rx_byte_q      <= rx_byte_d;
            brk_pend_q     <= brk_pend_d;
            ext_pend_q     <= ext_pend_d;
            tmo_q          <= tmo_d;
            nextdata_n_q   <= nextdata_n_d;
            key_code_q     <= key_code_d;
            key_ext_q      <= key_ext_d;
            key_valid_q    <= key_valid_d;
            key_pressed_q  <= key_pressed_d;
            key_repeat_q   <= key_repeat_d;
            key_count_q    <= key_count_d;
            err_overflow_q <= err_overflow_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        rx_byte_d      = rx_byte_q;
        brk_pend_d     = brk_pend_q;
        ext_pend_d     = ext_pend_q;
        tmo_d          = tmo_q;
        nextdata_n_d   = 1'b1;
        key_code_d     = key_code_q;
        key_ext_d      = key_ext_q;
        key_valid_d    = key_valid_q;
        key_pressed_d  = 1'b0;
        key_repeat_d   = 1'b0;
        key_count_d    = key_count_q;
        err_overflow_d = err_overflow_q | bus.overflow;

        case (state_q)
            IDLE: begin
                // The strobe is registered, so it drops in the same cycle the FSM enters POP.
                if (bus.ready) begin
                    rx_byte_d    = bus.fifo_data;
                    state_d      = POP;
                    nextdata_n_d = 1'b0;
                end
            end

            POP: begin
                state_d = SETTLE;
                if (rx_byte_q == CODE_EXT) begin
                    ext_pend_d = 1'b1;
                end else if (rx_byte_q == CODE_BRK) begin
                    brk_pend_d = 1'b1;
                end else if (brk_pend_q) begin
                    // Breaks of keys that were replaced or never held are dropped.
                    if (same_key && key_valid_q) begin
                        key_valid_d = 1'b0;
                    end
                    brk_pend_d = 1'b0;
                    ext_pend_d = 1'b0;
                end else begin
                    if (key_valid_q && same_key) begin
                        key_repeat_d = 1'b1;
                    end else begin
                        key_code_d    = rx_byte_q;
                        key_ext_d     = ext_pend_q;
                        key_valid_d   = 1'b1;
                        key_pressed_d = 1'b1;
                        key_count_d   = key_count_q + 8'd1;
                    end
                    brk_pend_d = 1'b0;
                    ext_pend_d = 1'b0;
                end
            end

            SETTLE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Decoding only happens in POP, so clearing there gives the decode priority.
        if (state_q == POP) begin
            tmo_d = '0;
        end else if (brk_pend_q || ext_pend_q) begin
            if (tmo_q == TMO_LIMIT) begin
                tmo_d      = '0;
                brk_pend_d = 1'b0;
                ext_pend_d = 1'b0;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end else begin
            tmo_d = '0;
        end
    end

    assign bus.nextdata_n   = nextdata_n_q;
    assign bus.key_code     = key_code_q;
    assign bus.key_ext      = key_ext_q;
    assign bus.key_valid    = key_valid_q;
    assign bus.key_pressed  = key_pressed_q;
    assign bus.key_repeat   = key_repeat_q;
    assign bus.key_count    = key_count_q;
    assign bus.err_overflow = err_overflow_q;

endmodule
